// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU controller:
// opcodes, FSM states, branch conditions and mux encodings.
package cpu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_LI  = 4'b1010;
  localparam logic [3:0] OP_LUI = 4'b1011;
  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_PCS = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  localparam logic [2:0] CC_NE = 3'b000;
  localparam logic [2:0] CC_EQ = 3'b001;
  localparam logic [2:0] CC_GT = 3'b010;
  localparam logic [2:0] CC_LT = 3'b011;
  localparam logic [2:0] CC_GE = 3'b100;
  localparam logic [2:0] CC_LE = 3'b101;
  localparam logic [2:0] CC_VS = 3'b110;
  localparam logic [2:0] CC_AL = 3'b111;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_REL = 2'b01;
  localparam logic [1:0] PC_REG = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PCS = 2'b10;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluator.
// Decides taken/not-taken from the ccc field and the flags.
module branch_cond
  import cpu_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic       z,
  input  logic       n,
  input  logic       v,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    unique case (ccc)
      CC_NE: taken = ~z;
      CC_EQ: taken = z;
      CC_GT: taken = ~z & ~n;
      CC_LT: taken = n;
      CC_GE: taken = z | (~z & ~n);
      CC_LE: taken = n | z;
      CC_VS: taken = v;
      CC_AL: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Multicycle CPU control FSM: fetch, decode, execute,
// memory and writeback sequencing plus flag register.
module cpu_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  output logic        imem_req,
  input  logic        imem_rdy,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_rdy,
  output logic [3:0]  alu_op,
  input  logic        alu_z,
  input  logic        alu_n,
  input  logic        alu_v,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_v,
  output logic        ir_en,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        halt
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        flag_z_q, flag_z_d;
  logic        flag_n_q, flag_n_d;
  logic        flag_v_q, flag_v_d;
  logic [3:0]  op;
  logic [2:0]  ccc;
  logic        taken;
  logic        unused_ir;

  assign op        = ir_q[15:12];
  assign ccc       = ir_q[11:9];
  assign unused_ir = ^ir_q[8:0];
  assign flag_z    = flag_z_q;
  assign flag_n    = flag_n_q;
  assign flag_v    = flag_v_q;

  // Branches see the flags as registered before this EXEC.
  branch_cond u_branch_cond (
    .ccc  (ccc),
    .z    (flag_z_q),
    .n    (flag_n_q),
    .v    (flag_v_q),
    .taken(taken)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      ir_q     <= '0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
      flag_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
      flag_v_q <= flag_v_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    flag_v_d = flag_v_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    alu_op   = 4'b0000;
    ir_en    = 1'b0;
    pc_en    = 1'b0;
    pc_sel   = PC_INC;
    rf_we    = 1'b0;
    wb_sel   = WB_ALU;
    halt     = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_rdy) begin
          ir_en   = 1'b1;
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = (op == OP_HLT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        alu_op = op;
        unique case (op)
          OP_ADD, OP_SUB: begin
            flag_z_d = alu_z;
            flag_n_d = alu_n;
            flag_v_d = alu_v;
            state_d  = S_WB;
          end
          OP_AND, OP_XOR, OP_NOT, OP_SHL: begin
            flag_z_d = alu_z;
            state_d  = S_WB;
          end
          OP_OR, OP_SHR, OP_LI, OP_LUI, OP_PCS: begin
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            state_d = S_MEM;
          end
          OP_B, OP_BR: begin
            pc_en = 1'b1;
            if (taken) begin
              pc_sel = (op == OP_B) ? PC_REL : PC_REG;
            end
            state_d = S_FETCH;
          end
          OP_HLT: begin
            state_d = S_HALT;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        alu_op   = op;
        dmem_req = 1'b1;
        dmem_we  = (op == OP_SW);
        if (dmem_rdy) begin
          if (op == OP_SW) begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        alu_op  = op;
        rf_we   = 1'b1;
        pc_en   = 1'b1;
        state_d = S_FETCH;
        if (op == OP_LW) begin
          wb_sel = WB_MEM;
        end else if (op == OP_PCS) begin
          wb_sel = WB_PCS;
        end
      end
      S_HALT: begin
        halt    = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase

    // Outputs stay quiet for as long as reset is held.
    if (rst) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      alu_op   = 4'b0000;
      ir_en    = 1'b0;
      pc_en    = 1'b0;
      pc_sel   = PC_INC;
      rf_we    = 1'b0;
      wb_sel   = WB_ALU;
      halt     = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl: per-cycle expected
// outputs, alu_op and flags from hand-written tables.
module tb_cpu_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] instr;
  logic        imem_req, imem_rdy;
  logic        dmem_req, dmem_we, dmem_rdy;
  logic [3:0]  alu_op;
  logic        alu_z, alu_n, alu_v;
  logic        flag_z, flag_n, flag_v;
  logic        ir_en, pc_en, rf_we, halt;
  logic [1:0]  pc_sel, wb_sel;

  logic [10:0] outs;
  logic [2:0]  flags;
  int          n_vec;
  int          n_err;

  typedef struct packed {
    logic        rst;
    logic [15:0] instr;
    logic        irdy;
    logic        drdy;
    logic [2:0]  alu;
    logic [10:0] exp;
    logic [3:0]  op;
    logic [2:0]  fl;
  } row_t;

  cpu_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .instr   (instr),
    .imem_req(imem_req),
    .imem_rdy(imem_rdy),
    .dmem_req(dmem_req),
    .dmem_we (dmem_we),
    .dmem_rdy(dmem_rdy),
    .alu_op  (alu_op),
    .alu_z   (alu_z),
    .alu_n   (alu_n),
    .alu_v   (alu_v),
    .flag_z  (flag_z),
    .flag_n  (flag_n),
    .flag_v  (flag_v),
    .ir_en   (ir_en),
    .pc_en   (pc_en),
    .pc_sel  (pc_sel),
    .rf_we   (rf_we),
    .wb_sel  (wb_sel),
    .halt    (halt)
  );

  assign outs = {imem_req, ir_en, dmem_req, dmem_we,
                 pc_en, pc_sel, rf_we, wb_sel, halt};
  assign flags = {flag_z, flag_n, flag_v};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic row_t r(
    input logic        rs,
    input logic [15:0] ins,
    input logic        ir,
    input logic        dr,
    input logic [2:0]  al,
    input logic [10:0] ex,
    input logic [3:0]  op,
    input logic [2:0]  fl
  );
    row_t t;
    t.rst   = rs;
    t.instr = ins;
    t.irdy  = ir;
    t.drdy  = dr;
    t.alu   = al;
    t.exp   = ex;
    t.op    = op;
    t.fl    = fl;
    return t;
  endfunction

  task automatic drive(input row_t t);
    rst      = t.rst;
    instr    = t.instr;
    imem_rdy = t.irdy;
    dmem_rdy = t.drdy;
    {alu_z, alu_n, alu_v} = t.alu;
  endtask

  task automatic test_reset;
    row_t v[$];
    v.push_back(r(1, 16'h0000, 0, 0, 3'b000, 11'h000, 4'h0, 3'b000));
    v.push_back(r(1, 16'hF000, 1, 1, 3'b000, 11'h000, 4'h0, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h400, 4'h0, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h400, 4'h0, 3'b000));
    foreach (v[i]) begin
      drive(v[i]);
      #1;
      n_vec++;
      if ({outs, alu_op, flags} !== {v[i].exp, v[i].op, v[i].fl}) begin
        n_err++;
        $display("FAIL reset[%0d] outs/op/fl got %h/%h/%b want %h/%h/%b",
                 i, outs, alu_op, flags, v[i].exp, v[i].op, v[i].fl);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_add;
    row_t v[$];
    v.push_back(r(0, 16'h0000, 1, 0, 3'b000, 11'h600, 4'h0, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h000, 4'h0, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b011, 11'h000, 4'h0, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h048, 4'h0, 3'b011));
    foreach (v[i]) begin
      drive(v[i]);
      #1;
      n_vec++;
      if ({outs, alu_op, flags} !== {v[i].exp, v[i].op, v[i].fl}) begin
        n_err++;
        $display("FAIL add[%0d] outs/op/fl got %h/%h/%b want %h/%h/%b",
                 i, outs, alu_op, flags, v[i].exp, v[i].op, v[i].fl);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_xor;
    row_t v[$];
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h400, 4'h0, 3'b011));
    v.push_back(r(0, 16'h4000, 1, 0, 3'b000, 11'h600, 4'h0, 3'b011));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h000, 4'h0, 3'b011));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b100, 11'h000, 4'h4, 3'b011));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h048, 4'h4, 3'b111));
    foreach (v[i]) begin
      drive(v[i]);
      #1;
      n_vec++;
      if ({outs, alu_op, flags} !== {v[i].exp, v[i].op, v[i].fl}) begin
        n_err++;
        $display("FAIL xor[%0d] outs/op/fl got %h/%h/%b want %h/%h/%b",
                 i, outs, alu_op, flags, v[i].exp, v[i].op, v[i].fl);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_branch;
    row_t v[$];
    v.push_back(r(0, 16'hC200, 1, 0, 3'b000, 11'h600, 4'h0, 3'b111));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h000, 4'h0, 3'b111));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h050, 4'hC, 3'b111));
    v.push_back(r(0, 16'h1000, 1, 0, 3'b000, 11'h600, 4'h0, 3'b111));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h000, 4'h0, 3'b111));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h000, 4'h1, 3'b111));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h048, 4'h1, 3'b000));
    v.push_back(r(0, 16'hC200, 1, 0, 3'b000, 11'h600, 4'h0, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h000, 4'h0, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b111, 11'h040, 4'hC, 3'b000));
    v.push_back(r(0, 16'hDE00, 1, 0, 3'b000, 11'h600, 4'h0, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h000, 4'h0, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h060, 4'hD, 3'b000));
    v.push_back(r(0, 16'hD400, 1, 0, 3'b000, 11'h600, 4'h0, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h000, 4'h0, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h060, 4'hD, 3'b000));
    v.push_back(r(0, 16'hC600, 1, 0, 3'b000, 11'h600, 4'h0, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h000, 4'h0, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h040, 4'hC, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h400, 4'h0, 3'b000));
    foreach (v[i]) begin
      drive(v[i]);
      #1;
      n_vec++;
      if ({outs, alu_op, flags} !== {v[i].exp, v[i].op, v[i].fl}) begin
        n_err++;
        $display("FAIL branch[%0d] outs/op/fl got %h/%h/%b want %h/%h/%b",
                 i, outs, alu_op, flags, v[i].exp, v[i].op, v[i].fl);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mem;
    row_t v[$];
    v.push_back(r(0, 16'h8000, 1, 1, 3'b000, 11'h600, 4'h0, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 1, 3'b000, 11'h000, 4'h0, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 1, 3'b000, 11'h000, 4'h8, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h100, 4'h8, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h100, 4'h8, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 1, 3'b000, 11'h100, 4'h8, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h04A, 4'h8, 3'b000));
    v.push_back(r(0, 16'h9000, 1, 0, 3'b000, 11'h600, 4'h0, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h000, 4'h0, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h000, 4'h9, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h180, 4'h9, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 1, 3'b000, 11'h1C0, 4'h9, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h400, 4'h0, 3'b000));
    foreach (v[i]) begin
      drive(v[i]);
      #1;
      n_vec++;
      if ({outs, alu_op, flags} !== {v[i].exp, v[i].op, v[i].fl}) begin
        n_err++;
        $display("FAIL mem[%0d] outs/op/fl got %h/%h/%b want %h/%h/%b",
                 i, outs, alu_op, flags, v[i].exp, v[i].op, v[i].fl);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_wb;
    row_t v[$];
    v.push_back(r(0, 16'hE000, 1, 0, 3'b000, 11'h600, 4'h0, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h000, 4'h0, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b111, 11'h000, 4'hE, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h04C, 4'hE, 3'b000));
    v.push_back(r(0, 16'hA000, 1, 0, 3'b000, 11'h600, 4'h0, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h000, 4'h0, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b111, 11'h000, 4'hA, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h048, 4'hA, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h400, 4'h0, 3'b000));
    foreach (v[i]) begin
      drive(v[i]);
      #1;
      n_vec++;
      if ({outs, alu_op, flags} !== {v[i].exp, v[i].op, v[i].fl}) begin
        n_err++;
        $display("FAIL wb[%0d] outs/op/fl got %h/%h/%b want %h/%h/%b",
                 i, outs, alu_op, flags, v[i].exp, v[i].op, v[i].fl);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_halt;
    row_t v[$];
    v.push_back(r(0, 16'h0000, 1, 0, 3'b000, 11'h600, 4'h0, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h000, 4'h0, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b111, 11'h000, 4'h0, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h048, 4'h0, 3'b111));
    v.push_back(r(0, 16'hF000, 1, 0, 3'b000, 11'h600, 4'h0, 3'b111));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h000, 4'h0, 3'b111));
    v.push_back(r(0, 16'h0000, 1, 0, 3'b000, 11'h001, 4'h0, 3'b111));
    v.push_back(r(0, 16'h0000, 1, 0, 3'b000, 11'h001, 4'h0, 3'b111));
    v.push_back(r(0, 16'h0000, 0, 1, 3'b000, 11'h001, 4'h0, 3'b111));
    v.push_back(r(1, 16'h0000, 0, 0, 3'b000, 11'h000, 4'h0, 3'b111));
    v.push_back(r(1, 16'h0000, 0, 0, 3'b000, 11'h000, 4'h0, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h400, 4'h0, 3'b000));
    foreach (v[i]) begin
      drive(v[i]);
      #1;
      n_vec++;
      if ({outs, alu_op, flags} !== {v[i].exp, v[i].op, v[i].fl}) begin
        n_err++;
        $display("FAIL halt[%0d] outs/op/fl got %h/%h/%b want %h/%h/%b",
                 i, outs, alu_op, flags, v[i].exp, v[i].op, v[i].fl);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_rst_mem;
    row_t v[$];
    v.push_back(r(0, 16'h8000, 1, 0, 3'b000, 11'h600, 4'h0, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h000, 4'h0, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h000, 4'h8, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h100, 4'h8, 3'b000));
    v.push_back(r(1, 16'h0000, 0, 0, 3'b000, 11'h000, 4'h0, 3'b000));
    v.push_back(r(1, 16'h0000, 1, 1, 3'b000, 11'h000, 4'h0, 3'b000));
    v.push_back(r(0, 16'h0000, 0, 0, 3'b000, 11'h400, 4'h0, 3'b000));
    foreach (v[i]) begin
      drive(v[i]);
      #1;
      n_vec++;
      if ({outs, alu_op, flags} !== {v[i].exp, v[i].op, v[i].fl}) begin
        n_err++;
        $display("FAIL rst_mem[%0d] outs/op/fl got %h/%h/%b want %h/%h/%b",
                 i, outs, alu_op, flags, v[i].exp, v[i].op, v[i].fl);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b1;
    instr    = '0;
    imem_rdy = 1'b0;
    dmem_rdy = 1'b0;
    alu_z    = 1'b0;
    alu_n    = 1'b0;
    alu_v    = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_add();
    test_xor();
    test_branch();
    test_mem();
    test_wb();
    test_halt();
    test_rst_mem();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  system clock, all state updates on rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 instr  in  16  instruction word from instruction memory, valid when imem_rdy=1; opcode=instr[15:12], ccc=instr[11:9].
REQ-005 imem_req  out  1  instruction fetch request.
REQ-006 imem_rdy  in  1  instruction memory data valid / handshake complete.
REQ-007 dmem_req  out  1  data memory access request.
REQ-008 dmem_we  out  1  data memory write enable, valid only with dmem_req.
REQ-009 dmem_rdy  in  1  data memory access complete.
REQ-010 alu_op  out  4  opcode driven to ALU.
REQ-011 alu_z, alu_n, alu_v  in  1 each  ALU flag results for the current alu_op.
REQ-012 flag_z, flag_n, flag_v  out  1 each  registered flag state.
REQ-013 ir_en  out  1  instruction register load strobe.
REQ-014 pc_en  out  1  PC update strobe.
REQ-015 pc_sel  out  2  PC source: 00 PC+2, 01 PC+2+(imm<<1), 10 register rs.
REQ-016 rf_we  out  1  register file write enable.
REQ-017 wb_sel  out  2  writeback source: 00 ALU, 01 memory data, 10 PC+2 (PCS).
REQ-018 halt  out  1  processor halted.

Function
REQ-019 The FSM SHALL have states FETCH, DECODE, EXEC, MEM, WB, HALT, and SHALL hold an internal copy of the instruction latched on ir_en.
REQ-020 FETCH: imem_req=1 each cycle until imem_rdy=1; in the imem_rdy cycle ir_en=1 and next state is DECODE.
REQ-021 DECODE: one cycle; opcode 1111 (HLT) -> HALT with no pc_en; otherwise -> EXEC.
REQ-022 EXEC: one cycle, with alu_op=opcode held through EXEC, MEM and WB.
REQ-023 EXEC next state: opcodes 0000-0111, 1010, 1011, 1110 -> WB; 1000, 1001 -> MEM; 1100, 1101 -> FETCH.
REQ-024 Flag update in the EXEC cycle: 0000/0001 load Z,N,V from the ALU; 0010/0100/0101/0110 load Z only; all other opcodes leave the flags unchanged.
REQ-025 B (1100)/BR (1101): evaluate ccc against the flag values registered before this EXEC cycle; pc_en=1 in EXEC; pc_sel=01 (B) or 10 (BR) if taken, else 00.
REQ-026 ccc: 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1; 100 Z=1|(Z=0&N=0); 101 N=1|Z=1; 110 V=1; 111 always.
REQ-027 MEM: dmem_req=1 until dmem_rdy=1, with dmem_we=1 for SW (1001) and 0 for LW (1000); on dmem_rdy, SW -> FETCH with pc_en=1, pc_sel=00, and LW -> WB.
REQ-028 WB: one cycle with rf_we=1 and pc_en=1, pc_sel=00; wb_sel=01 for LW, 10 for PCS, 00 otherwise; next state FETCH.
REQ-029 HALT: halt=1, and all request, strobe and enable outputs are 0; the state SHALL be left only by rst.
REQ-030 pc_en, ir_en and rf_we SHALL each be single-cycle pulses, with at most one pc_en per instruction.
REQ-031 Outside their defined states, imem_req, dmem_req, dmem_we, ir_en, pc_en and rf_we SHALL be 0, and pc_sel and wb_sel SHALL be 00.
REQ-032 A ready input asserted while the matching request is low SHALL be ignored.

Reset
REQ-033 rst=1 at a clock edge SHALL force state FETCH, flags 0 and the internal instruction 0, and SHALL deassert all outputs including halt, in any state including mid-MEM.
REQ-034 Fetch SHALL begin with imem_req=1 in the first cycle after rst deasserts.

Structure
REQ-035 The shared package cpu_pkg SHALL hold the opcode constants, the state enum, the ccc encodings, and the pc_sel and wb_sel encodings.
REQ-036 Branch evaluation SHALL be a combinational sub-module branch_cond with inputs (ccc, Z, N, V) and output taken.

Verification
REQ-037 ADD with imem_rdy at the 1st request cycle and ALU giving Z=0, N=1, V=1: sequence FETCH-DECODE-EXEC-WB; flags 0/1/1 after EXEC; rf_we=1 and pc_en=1 with pc_sel=00 in WB.
REQ-038 XOR with alu_z=1 while prior N=1, V=1: flag_z=1, N and V still 1.
REQ-039 B ccc=001 with Z=1: pc_en=1 with pc_sel=01 in EXEC. Same with Z=0: pc_sel=00. BR ccc=111: pc_sel=10.
REQ-040 LW with dmem_rdy after 3 cycles: dmem_req high for 3 cycles with dmem_we=0, then WB with wb_sel=01. SW: dmem_we=1 and no rf_we.
REQ-041 HLT: halt=1 from the cycle after DECODE with no pc_en; imem_rdy pulses are ignored; rst returns to FETCH with flags 0.
REQ-042 rst asserted during MEM wait: the next cycle has all outputs 0 and the state is FETCH.
